// File: rtl/pipelined_instruction_decoder.sv
// -----------------------------------------------------------------------------
// pipelined_instruction_decoder
//
// Purpose
//   A single registered pipeline stage between fetch and execute. Each
//   accepted 32-bit MIPS word is decoded into datapath controls, a resolved
//   register write address, an extended immediate and an illegal flag. The
//   stage detects lw load-use hazards against the instruction waiting at its
//   input and inserts STALL_CYCLES bubbles. Without a hazard it sustains one
//   instruction per cycle.
//
// Parameters
//   IMM_WIDTH     width of imm_ext (>= 16)
//   LINK_REG      write address used by jal
//   STALL_CYCLES  bubbles inserted per load-use hazard (>= 1)
//   CNT_WIDTH     width of the optional performance counters
//
// Optional feature
//   DECODER_PERF_CNT_EN  when defined, adds perf_decoded and perf_stalls.
//                        perf_decoded counts accepted instructions and
//                        perf_stalls counts inserted bubbles. Both wrap to 0.
//                        Reset clears them. flush does not.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush                 sync: drop stage contents and hazard state
//   in_valid / in_ready   fetch handshake, instruction = 32-bit word
//   out_valid / out_ready execute handshake for the decoded bundle
//   reg_dst               0 rt, 1 rd, 2 ra
//   alu_src               0 immediate, 1 PC, 2 Db
//   alu_ctrl              0 ADD, 1 SUB, 3 SLT
//   ext_method .. inv_zero single-bit controls
//   rs, rt, wr_addr       source fields and resolved destination
//   imm_ext               instr[15:0], zero-extended when ext_method=1,
//                         otherwise sign-extended
//   jump_target           instr[25:0]
//   illegal               unsupported opcode/funct (all controls 0)
// -----------------------------------------------------------------------------
module pipelined_instruction_decoder #(
   parameter int         IMM_WIDTH    = 32,
   parameter logic [4:0] LINK_REG     = 5'd31,
   parameter int         STALL_CYCLES = 1,
   parameter int         CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          instruction,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           reg_dst,
   output logic [1:0]           alu_src,
   output logic [2:0]           alu_ctrl,
   output logic                 ext_method,
   output logic                 reg_wr,
   output logic                 branch,
   output logic                 jump,
   output logic                 mem_wr,
   output logic                 mem_to_reg,
   output logic                 jump_reg,
   output logic                 inv_zero,
   output logic [4:0]           rs,
   output logic [4:0]           rt,
   output logic [4:0]           wr_addr,
   output logic [IMM_WIDTH-1:0] imm_ext,
   output logic [25:0]          jump_target,
   output logic                 illegal
`ifdef DECODER_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] perf_decoded,
   output logic [CNT_WIDTH-1:0] perf_stalls
`endif
);

   // Parameter sanity, evaluated at elaboration only.
   if (IMM_WIDTH < 16 || STALL_CYCLES < 1 || CNT_WIDTH < 1) begin : g_param_check
      $error("pipelined_instruction_decoder: IMM_WIDTH>=16, STALL_CYCLES>=1, CNT_WIDTH>=1 required");
   end

   // ---------------------------------------------------------------------------
   // Encodings
   // ---------------------------------------------------------------------------
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [1:0] {DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2} reg_dst_e;
   typedef enum logic [1:0] {SRC_IMM = 2'd0, SRC_PC = 2'd1, SRC_DB = 2'd2} alu_src_e;
   typedef enum logic [2:0] {ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_SLT = 3'd3} alu_ctrl_e;
   typedef enum logic       {ST_RUN = 1'b0, ST_STALL = 1'b1} state_e;

   typedef struct packed {
      reg_dst_e               reg_dst;
      alu_src_e               alu_src;
      alu_ctrl_e              alu_ctrl;
      logic                   ext_method;
      logic                   reg_wr;
      logic                   branch;
      logic                   jump;
      logic                   mem_wr;
      logic                   mem_to_reg;
      logic                   jump_reg;
      logic                   inv_zero;
      logic [4:0]             rs;
      logic [4:0]             rt;
      logic [4:0]             wr_addr;
      logic [IMM_WIDTH-1:0]   imm_ext;
      logic [25:0]            jump_target;
      logic                   illegal;
   } bundle_t;

   // Stall counter only needs to hold STALL_CYCLES-1.
   localparam int SC_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

   // ---------------------------------------------------------------------------
   // Combinational decode of the word presented by fetch
   // ---------------------------------------------------------------------------
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [15:0] imm16;
   bundle_t     dec;
   logic        uses_rs;
   logic        uses_rt;
   logic        is_lw;

   assign opcode = instruction[31:26];
   assign funct  = instruction[5:0];
   assign imm16  = instruction[15:0];

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path through
      // the case statements can leave it unassigned and infer a latch.
      dec     = '0;
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      is_lw   = 1'b0;

      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_ADDU: begin
                  dec.reg_dst  = DST_RD;
                  dec.alu_src  = SRC_DB;
                  dec.alu_ctrl = ALU_ADD;
                  dec.reg_wr   = 1'b1;
                  uses_rs      = 1'b1;
                  uses_rt      = 1'b1;
               end
               FN_SLT: begin
                  dec.reg_dst  = DST_RD;
                  dec.alu_src  = SRC_DB;
                  dec.alu_ctrl = ALU_SLT;
                  dec.reg_wr   = 1'b1;
                  uses_rs      = 1'b1;
                  uses_rt      = 1'b1;
               end
               FN_JR: begin
                  // Target comes from rs; nothing is written back.
                  dec.jump_reg = 1'b1;
                  uses_rs      = 1'b1;
               end
               default: dec.illegal = 1'b1;
            endcase
         end
         OP_ADDI: begin
            dec.reg_wr = 1'b1;
            uses_rs    = 1'b1;
         end
         OP_ADDIU: begin
            dec.reg_wr     = 1'b1;
            dec.ext_method = 1'b1;
            uses_rs        = 1'b1;
         end
         OP_JAL: begin
            // Link address is computed from PC by the ALU.
            dec.reg_dst = DST_RA;
            dec.alu_src = SRC_PC;
            dec.reg_wr  = 1'b1;
            dec.jump    = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            dec.alu_src  = SRC_DB;
            dec.alu_ctrl = ALU_SUB;
            dec.branch   = 1'b1;
            dec.inv_zero = (opcode == OP_BNE);
            uses_rs      = 1'b1;
            uses_rt      = 1'b1;
         end
         OP_LW: begin
            dec.reg_wr     = 1'b1;
            dec.mem_to_reg = 1'b1;
            uses_rs        = 1'b1;
            is_lw          = 1'b1;
         end
         OP_SW: begin
            dec.mem_wr = 1'b1;
            uses_rs    = 1'b1;
            uses_rt    = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase

      // Raw fields pass through for every word, legal or not.
      dec.rs          = instruction[25:21];
      dec.rt          = instruction[20:16];
      dec.jump_target = instruction[25:0];
      dec.imm_ext     = dec.ext_method ? IMM_WIDTH'(imm16)
                                       : IMM_WIDTH'($signed(imm16));

      case (dec.reg_dst)
         DST_RD:  dec.wr_addr = instruction[15:11];
         DST_RA:  dec.wr_addr = LINK_REG;
         default: dec.wr_addr = instruction[20:16];
      endcase
   end

   // ---------------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------------
   // The record only ever holds a non-zero rt, so a $0 read can never match.
   logic       lw_pend;
   logic [4:0] lw_rt;
   logic       rd_match;

   assign rd_match = lw_pend && ((uses_rs && (dec.rs == lw_rt)) ||
                                 (uses_rt && (dec.rt == lw_rt)));

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   state_e           state, state_nx;
   logic [SC_W-1:0]  stall_cnt, stall_cnt_nx;
   logic             advance;
   logic             accept;
   logic             bubble;
   logic             stall_end;

   assign advance = !out_valid || out_ready;

   // in_ready is built from the word and stage state only; in_valid merely
   // qualifies the RUN->STALL transition, so fetch never sees a ready that
   // depends on its own valid.
   always_comb begin
      state_nx     = state;
      stall_cnt_nx = stall_cnt;
      in_ready     = 1'b0;
      bubble       = 1'b0;
      stall_end    = 1'b0;

      if (flush) begin
         state_nx = ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               if (advance) begin
                  if (!rd_match) begin
                     in_ready = 1'b1;
                  end else if (in_valid) begin
                     // This cycle's empty output slot is the first bubble.
                     state_nx     = ST_STALL;
                     stall_cnt_nx = SC_W'(STALL_CYCLES - 1);
                     bubble       = 1'b1;
                  end
               end
            end
            ST_STALL: begin
               if (advance) begin
                  if (stall_cnt == '0) begin
                     // Bubbles are complete: the load result is now forwardable,
                     // so the held instruction enters the stage on this edge.
                     state_nx  = ST_RUN;
                     stall_end = 1'b1;
                     in_ready  = 1'b1;
                  end else begin
                     stall_cnt_nx = stall_cnt - SC_W'(1);
                     bubble       = 1'b1;
                  end
               end
            end
            default: state_nx = ST_RUN;
         endcase
      end
   end

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         stall_cnt <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every flop
         // in this module samples the values from before the clock edge.
         state     <= state_nx;
         stall_cnt <= stall_cnt_nx;
      end
   end

   // Hazard record: written on every acceptance; a stall end or flush drops it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lw_pend <= 1'b0;
         lw_rt   <= '0;
      end else if (flush) begin
         lw_pend <= 1'b0;
      end else if (accept) begin
         lw_pend <= is_lw && (dec.rt != 5'd0);
         lw_rt   <= dec.rt;
      end else if (stall_end) begin
         lw_pend <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Output stage
   // ---------------------------------------------------------------------------
   bundle_t out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the data bundle is reset too, not just out_valid, so execute
         // never observes X on controls that it may sample unqualified.
         out_valid <= 1'b0;
         out_q     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (advance) begin
         // Without an acceptance the slot becomes a bubble; data is kept.
         out_valid <= accept;
         if (accept) begin
            out_q <= dec;
         end
      end
   end

   assign reg_dst     = out_q.reg_dst;
   assign alu_src     = out_q.alu_src;
   assign alu_ctrl    = out_q.alu_ctrl;
   assign ext_method  = out_q.ext_method;
   assign reg_wr      = out_q.reg_wr;
   assign branch      = out_q.branch;
   assign jump        = out_q.jump;
   assign mem_wr      = out_q.mem_wr;
   assign mem_to_reg  = out_q.mem_to_reg;
   assign jump_reg    = out_q.jump_reg;
   assign inv_zero    = out_q.inv_zero;
   assign rs          = out_q.rs;
   assign rt          = out_q.rt;
   assign wr_addr     = out_q.wr_addr;
   assign imm_ext     = out_q.imm_ext;
   assign jump_target = out_q.jump_target;
   assign illegal     = out_q.illegal;

   // ---------------------------------------------------------------------------
   // Optional performance counters
   // ---------------------------------------------------------------------------
`ifdef DECODER_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_decoded <= '0;
         perf_stalls  <= '0;
      end else begin
         if (accept) begin
            perf_decoded <= perf_decoded + CNT_WIDTH'(1);
         end
         if (bubble) begin
            perf_stalls <= perf_stalls + CNT_WIDTH'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_instruction_decoder
//
// Scoreboard bench: the driver pushes a hand-computed expected bundle each time
// an instruction is accepted; an independent monitor pops and compares every
// bundle the decoder hands to execute. Directed checks cover reset, back-to-back
// issue, load-use bubbles, output hold under back-pressure, and flush in STALL.
// Optional perf counters are checked when DECODER_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipelined_instruction_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instruction = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [1:0]  reg_dst;
   logic [1:0]  alu_src;
   logic [2:0]  alu_ctrl;
   logic        ext_method, reg_wr, branch, jump, mem_wr, mem_to_reg, jump_reg, inv_zero;
   logic [4:0]  rs, rt, wr_addr;
   logic [31:0] imm_ext;
   logic [25:0] jump_target;
   logic        illegal;
`ifdef DECODER_PERF_CNT_EN
   logic [15:0] perf_decoded;
   logic [15:0] perf_stalls;
`endif

   always #5 clk = ~clk;

   pipelined_instruction_decoder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instruction (instruction),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .reg_dst     (reg_dst),
      .alu_src     (alu_src),
      .alu_ctrl    (alu_ctrl),
      .ext_method  (ext_method),
      .reg_wr      (reg_wr),
      .branch      (branch),
      .jump        (jump),
      .mem_wr      (mem_wr),
      .mem_to_reg  (mem_to_reg),
      .jump_reg    (jump_reg),
      .inv_zero    (inv_zero),
      .rs          (rs),
      .rt          (rt),
      .wr_addr     (wr_addr),
      .imm_ext     (imm_ext),
      .jump_target (jump_target),
      .illegal     (illegal)
`ifdef DECODER_PERF_CNT_EN
      ,
      .perf_decoded(perf_decoded),
      .perf_stalls (perf_stalls)
`endif
   );

   // ctl = {ext_method, reg_wr, branch, jump, mem_wr, mem_to_reg, jump_reg, inv_zero}
   typedef struct packed {
      logic [1:0]  reg_dst;
      logic [1:0]  alu_src;
      logic [2:0]  alu_ctrl;
      logic [7:0]  ctl;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  wr_addr;
      logic [31:0] imm_ext;
      logic [25:0] jump_target;
      logic        illegal;
   } bundle_t;

   bundle_t act;
   assign act = {reg_dst, alu_src, alu_ctrl,
                 ext_method, reg_wr, branch, jump, mem_wr, mem_to_reg, jump_reg, inv_zero,
                 rs, rt, wr_addr, imm_ext, jump_target, illegal};

   function automatic bundle_t mk(input logic [1:0] d, input logic [1:0] s, input logic [2:0] a,
                                  input logic [7:0] c, input logic [4:0] f_rs, input logic [4:0] f_rt,
                                  input logic [4:0] w, input logic [31:0] imm, input logic [25:0] jt,
                                  input logic ill);
      return {d, s, a, c, f_rs, f_rt, w, imm, jt, ill};
   endfunction

   // Instruction words and their hand-decoded bundles.
   localparam logic [31:0] W_ADDIU = 32'h241D3FFC;
   localparam logic [31:0] W_JAL   = 32'h0C000009;
   localparam logic [31:0] W_LW    = 32'h8FA20000;
   localparam logic [31:0] W_ADD   = 32'h00421820;
   localparam logic [31:0] W_ADDU  = 32'h00001821;
   localparam logic [31:0] W_ILL   = 32'hFC000000;
   localparam logic [31:0] W_BEQ   = 32'h10430004;
   localparam logic [31:0] W_BNE   = 32'h1443FFFF;
   localparam logic [31:0] W_SW    = 32'hAFA30008;
   localparam logic [31:0] W_SLT   = 32'h0062202A;
   localparam logic [31:0] W_JR    = 32'h03E00008;
   localparam logic [31:0] W_ADDI  = 32'h2008FFFF;

   bundle_t e_addiu, e_jal, e_lw, e_add, e_addu, e_ill, e_beq, e_bne, e_sw, e_slt, e_jr, e_addi;

   initial begin
      e_addiu = mk(2'd0, 2'd0, 3'd0, 8'b1100_0000, 5'd0,  5'd29, 5'd29, 32'h00003FFC, 26'h01D3FFC, 1'b0);
      e_jal   = mk(2'd2, 2'd1, 3'd0, 8'b0101_0000, 5'd0,  5'd0,  5'd31, 32'h00000009, 26'h0000009, 1'b0);
      e_lw    = mk(2'd0, 2'd0, 3'd0, 8'b0100_0100, 5'd29, 5'd2,  5'd2,  32'h00000000, 26'h3A20000, 1'b0);
      e_add   = mk(2'd1, 2'd2, 3'd0, 8'b0100_0000, 5'd2,  5'd2,  5'd3,  32'h00001820, 26'h0421820, 1'b0);
      e_addu  = mk(2'd1, 2'd2, 3'd0, 8'b0100_0000, 5'd0,  5'd0,  5'd3,  32'h00001821, 26'h0001821, 1'b0);
      e_ill   = mk(2'd0, 2'd0, 3'd0, 8'b0000_0000, 5'd0,  5'd0,  5'd0,  32'h00000000, 26'h0000000, 1'b1);
      e_beq   = mk(2'd0, 2'd2, 3'd1, 8'b0010_0000, 5'd2,  5'd3,  5'd3,  32'h00000004, 26'h0430004, 1'b0);
      e_bne   = mk(2'd0, 2'd2, 3'd1, 8'b0010_0001, 5'd2,  5'd3,  5'd3,  32'hFFFFFFFF, 26'h043FFFF, 1'b0);
      e_sw    = mk(2'd0, 2'd0, 3'd0, 8'b0000_1000, 5'd29, 5'd3,  5'd3,  32'h00000008, 26'h3A30008, 1'b0);
      e_slt   = mk(2'd1, 2'd2, 3'd3, 8'b0100_0000, 5'd3,  5'd2,  5'd4,  32'h0000202A, 26'h062202A, 1'b0);
      e_jr    = mk(2'd0, 2'd0, 3'd0, 8'b0000_0010, 5'd31, 5'd0,  5'd0,  32'h00000008, 26'h3E00008, 1'b0);
      e_addi  = mk(2'd0, 2'd0, 3'd0, 8'b0100_0000, 5'd0,  5'd8,  5'd8,  32'hFFFFFFFF, 26'h008FFFF, 1'b0);
   end

   int      n_checks = 0;
   int      n_errors = 0;
   int      cyc = 0;
   int      n_out = 0;
   int      last_out_cyc = 0;
   int      prev_out_cyc = 0;
   bundle_t exp_q[$];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: every bundle execute takes is compared against the queue head.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_output", exp_q.size(), 1);
         end else begin
            check($sformatf("bundle%0d", n_out), act, exp_q.pop_front());
            prev_out_cyc = last_out_cyc;
            last_out_cyc = cyc;
         end
         n_out++;
      end
   end

   // Present a word until accepted; the expected bundle is queued at the edge
   // the handshake completes. waits = cycles in_ready stayed low.
   task automatic send(input logic [31:0] w, input bundle_t e, output int waits);
      bit done;
      done        = 1'b0;
      waits       = 0;
      in_valid    = 1'b1;
      instruction = w;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            done = 1'b1;
         end else begin
            waits++;
            if (waits > 20) begin
               check("send_timeout", waits, 0);
               done = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_bundle", act, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back independent instructions at full throughput.
      send(W_ADDIU, e_addiu, w);
      send(W_JAL, e_jal, w);
      check("jal_waits", w, 0);
      drain();
      check("jal_latency", last_out_cyc - prev_out_cyc, 1);

      // Load-use hazard: exactly one bubble, add emitted two cycles after lw.
      send(W_LW, e_lw, w);
      send(W_ADD, e_add, w);
      check("hazard_waits", w, 1);
      drain();
      check("hazard_spacing", last_out_cyc - prev_out_cyc, 2);

      // lw followed by a reader of $0 only: no bubble.
      send(W_LW, e_lw, w);
      send(W_ADDU, e_addu, w);
      check("no_hazard_waits", w, 0);
      drain();
      check("no_hazard_spacing", last_out_cyc - prev_out_cyc, 1);

      // Remaining opcodes, back to back.
      send(W_BEQ, e_beq, w);
      send(W_BNE, e_bne, w);
      send(W_SW, e_sw, w);
      send(W_SLT, e_slt, w);
      send(W_JR, e_jr, w);
      send(W_ADDI, e_addi, w);
      check("addi_waits", w, 0);
      drain();

      // Back-pressure: illegal word held three cycles, fetch blocked.
      out_ready = 1'b0;
      send(W_ILL, e_ill, w);
      in_valid    = 1'b1;
      instruction = W_ADDI;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("hold_bundle%0d", i), {out_valid, act}, {1'b1, e_ill});
         check($sformatf("hold_in_ready%0d", i), in_ready, 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(W_ADDI, e_addi, w);
      drain();

      // Flush while in STALL drops the stall and the hazard record.
      send(W_LW, e_lw, w);
      in_valid    = 1'b1;
      instruction = W_ADD;
      @(negedge clk);
      check("flush_pre_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      check("flush_in_ready", in_ready, 0);
      check("flush_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      send(W_ADD, e_add, w);
      check("post_flush_waits", w, 0);
      drain();

`ifdef DECODER_PERF_CNT_EN
      // 16 accepted words; one bubble from the hazard test, one before the flush.
      check("perf_decoded", perf_decoded, 16);
      check("perf_stalls", perf_stalls, 2);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
